// File: rtl/div_sqrt_seq_pkg.sv
// Shared types and sizing helpers for the non-restoring divide/square-root sequencer.
package div_sqrt_seq_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DIV_ITER  = 2'd1,
    SQRT_ITER = 2'd2,
    CORR      = 2'd3
  } seq_state_t;

  // Guard bits above the mantissa so the signed partial remainder never overflows.
  localparam int unsigned REM_GUARD_BITS = 3;

  function automatic int unsigned rem_width(input int unsigned width);
    return width + REM_GUARD_BITS;
  endfunction

  function automatic int unsigned iter_count(input int unsigned width, input logic is_sqrt);
    return is_sqrt ? width : width + 1;
  endfunction

endpackage

// File: rtl/div_sqrt_nr_step.sv
// One non-restoring recurrence step: add or subtract the selected operand from the
// shifted partial remainder; the result bit is set when the new remainder is non-negative.
module div_sqrt_nr_step #(
  parameter int unsigned RW = 28
) (
  input  logic [RW-1:0] rem_shifted,
  input  logic [RW-1:0] operand,
  input  logic          subtract,
  output logic [RW-1:0] rem_next,
  output logic          q_bit
);

  always_comb begin
    rem_next = subtract ? (rem_shifted - operand) : (rem_shifted + operand);
    q_bit    = ~rem_next[RW-1];
  end

endmodule

// File: rtl/div_sqrt_nr_sequencer.sv
// Non-restoring mantissa divide / square-root sequencer, one result bit per cycle.
// Optional early termination on a zero remainder: define DIV_SQRT_EARLY_TERM_EN.
module div_sqrt_nr_sequencer
  import div_sqrt_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 25
) (
  input  logic             Clk_CI,
  input  logic             Rst_RI,
  input  logic             Div_start_SI,
  input  logic             Sqrt_start_SI,
  input  logic             Kill_SI,
  input  logic [WIDTH-1:0] Mant_a_DI,
  input  logic [WIDTH-1:0] Mant_b_DI,
  output logic             Ready_SO,
  output logic             Busy_SO,
  output logic             Done_SO,
  output logic [WIDTH:0]   Quotient_DO,
  output logic             Sticky_SO
);

  localparam int unsigned DIV_ITERS  = iter_count(WIDTH, 1'b0);
  localparam int unsigned SQRT_ITERS = iter_count(WIDTH, 1'b1);
  localparam int unsigned RW         = rem_width(WIDTH);
  localparam int unsigned CW         = $clog2(DIV_ITERS + 1);

  seq_state_t         state, state_next;
  logic [RW-1:0]      rem;
  logic [WIDTH-1:0]   divisor;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     quot;
  logic [2*WIDTH-1:0] rad;
  logic               op_sqrt;
  logic [WIDTH:0]     quotient_q;
  logic               sticky_q;
  logic               done_q;

  logic               start_div, start_sqrt;
  logic [RW-1:0]      step_shifted, step_operand, step_rem;
  logic               step_sub, step_q;
  logic [RW-1:0]      corrected;
  logic [WIDTH:0]     quot_shift, quot_next;
  logic               early_term;

  assign start_div  = Div_start_SI & ~Kill_SI;
  assign start_sqrt = Sqrt_start_SI & ~Div_start_SI & ~Kill_SI;

  // The step unit also performs the final add-back in CORR (subtract forced low).
  always_comb begin
    step_shifted = '0;
    step_operand = '0;
    step_sub     = 1'b0;
    case (state)
      DIV_ITER: begin
        step_shifted = (cnt == CW'(DIV_ITERS)) ? rem : {rem[RW-2:0], 1'b0};
        step_operand = {{(RW-WIDTH){1'b0}}, divisor};
        step_sub     = ~rem[RW-1];
      end
      SQRT_ITER: begin
        step_shifted = {rem[RW-3:0], rad[2*WIDTH-1 -: 2]};
        step_operand = {1'b0, quot[WIDTH-1:0], ~rem[RW-1] ? 2'b01 : 2'b11};
        step_sub     = ~rem[RW-1];
      end
      CORR: begin
        step_shifted = rem;
        step_operand = op_sqrt ? {2'b00, quot[WIDTH-1:0], 1'b1}
                               : {{(RW-WIDTH){1'b0}}, divisor};
        step_sub     = 1'b0;
      end
      default: ;
    endcase
  end

  div_sqrt_nr_step #(.RW(RW)) u_step (
    .rem_shifted (step_shifted),
    .operand     (step_operand),
    .subtract    (step_sub),
    .rem_next    (step_rem),
    .q_bit       (step_q)
  );

  assign corrected  = rem[RW-1] ? step_rem : rem;
  assign quot_shift = {quot[WIDTH-1:0], step_q};

`ifdef DIV_SQRT_EARLY_TERM_EN
  // A zero sqrt remainder only ends the operation once no radicand bits remain.
  always_comb begin
    early_term = 1'b0;
    if (state == DIV_ITER)
      early_term = (step_rem == '0);
    else if (state == SQRT_ITER)
      early_term = (step_rem == '0) && (rad[2*WIDTH-3:0] == '0);
    quot_next = early_term ? (quot_shift << (cnt - CW'(1))) : quot_shift;
  end
`else
  assign early_term = 1'b0;
  assign quot_next  = quot_shift;
`endif

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_div)       state_next = DIV_ITER;
        else if (start_sqrt) state_next = SQRT_ITER;
      end
      DIV_ITER, SQRT_ITER: begin
        if (Kill_SI)                              state_next = IDLE;
        else if (cnt == CW'(1) || early_term)     state_next = CORR;
      end
      CORR:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      rem        <= '0;
      divisor    <= '0;
      cnt        <= '0;
      quot       <= '0;
      rad        <= '0;
      op_sqrt    <= 1'b0;
      quotient_q <= '0;
      sticky_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start_div) begin
            rem     <= {{(RW-WIDTH){1'b0}}, Mant_a_DI};
            divisor <= Mant_b_DI;
            cnt     <= CW'(DIV_ITERS);
            quot    <= '0;
            op_sqrt <= 1'b0;
          end else if (start_sqrt) begin
            rem     <= '0;
            rad     <= {Mant_a_DI, {WIDTH{1'b0}}};
            cnt     <= CW'(SQRT_ITERS);
            quot    <= '0;
            op_sqrt <= 1'b1;
          end
        end
        DIV_ITER, SQRT_ITER: begin
          if (!Kill_SI) begin
            rem  <= step_rem;
            quot <= quot_next;
            cnt  <= cnt - CW'(1);
            if (state == SQRT_ITER) rad <= {rad[2*WIDTH-3:0], 2'b00};
          end
        end
        CORR: begin
          if (!Kill_SI) begin
            quotient_q <= quot;
            sticky_q   <= (corrected != '0);
            done_q     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Ready_SO    = (state == IDLE);
  assign Busy_SO     = (state != IDLE);
  assign Done_SO     = done_q;
  assign Quotient_DO = quotient_q;
  assign Sticky_SO   = sticky_q;

endmodule

// File: tb/tb_div_sqrt_nr_sequencer.sv
// Self-checking bench for div_sqrt_nr_sequencer at WIDTH=8: directed table,
// randomized operations against an arithmetic reference, and control corner cases.
module tb_div_sqrt_nr_sequencer;

  logic       clk = 1'b0;
  logic       rst, div_start, sqrt_start, kill;
  logic [7:0] a, b;
  logic       ready, busy, done, sticky;
  logic [8:0] quot;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_sqrt_nr_sequencer #(.WIDTH(8)) dut (
    .Clk_CI        (clk),
    .Rst_RI        (rst),
    .Div_start_SI  (div_start),
    .Sqrt_start_SI (sqrt_start),
    .Kill_SI       (kill),
    .Mant_a_DI     (a),
    .Mant_b_DI     (b),
    .Ready_SO      (ready),
    .Busy_SO       (busy),
    .Done_SO       (done),
    .Quotient_DO   (quot),
    .Sticky_SO     (sticky)
  );

  typedef struct {
    bit         sq;
    bit         both;
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] q;
    logic       s;
    int         lat;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Reference: quotient = floor(A*2^8/B); root = floor(sqrt(A*2^8)).
  function automatic void model(input bit sq, input logic [7:0] va, input logic [7:0] vb,
                                output logic [8:0] q, output logic s);
    int unsigned num, r;
    num = int'(va) << 8;
    if (!sq) begin
      q = 9'(num / int'(vb));
      s = (num % int'(vb)) != 0;
    end else begin
      r = 0;
      while ((r + 1) * (r + 1) <= num) r++;
      q = 9'(r);
      s = (r * r) != num;
    end
  endfunction

  task automatic run_op(input bit ds, input bit ss, input logic [7:0] va, input logic [7:0] vb,
                        output logic [8:0] q, output logic s, output int lat);
    div_start  = ds;
    sqrt_start = ss;
    a = va;
    b = vb;
    tick();
    div_start  = 1'b0;
    sqrt_start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    q = quot;
    s = sticky;
    if (!done) lat = -1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [8:0] q, exp_q;
    logic       s, exp_s;
    int         lat;
    bit         seen, is_sq;
    logic [7:0] ra, rb;

    vecs[0] = '{sq:0, both:0, a:8'h80, b:8'h80, q:9'h100, s:1'b0, lat:11};
    vecs[1] = '{sq:0, both:0, a:8'h80, b:8'hC0, q:9'h0AA, s:1'b1, lat:11};
    vecs[2] = '{sq:1, both:0, a:8'h90, b:8'h00, q:9'h0C0, s:1'b0, lat:10};
    vecs[3] = '{sq:1, both:0, a:8'h80, b:8'h00, q:9'h0B5, s:1'b1, lat:10};
    vecs[4] = '{sq:0, both:0, a:8'hFF, b:8'h80, q:9'h1FE, s:1'b0, lat:11};
    vecs[5] = '{sq:0, both:0, a:8'h80, b:8'hFF, q:9'h080, s:1'b1, lat:11};
    vecs[6] = '{sq:1, both:0, a:8'hFF, b:8'h00, q:9'h0FF, s:1'b1, lat:10};
    vecs[7] = '{sq:1, both:0, a:8'h40, b:8'h00, q:9'h080, s:1'b0, lat:10};
    vecs[8] = '{sq:0, both:1, a:8'h80, b:8'hC0, q:9'h0AA, s:1'b1, lat:11};

    rst = 1'b1; div_start = 1'b0; sqrt_start = 1'b0; kill = 1'b0; a = '0; b = '0;
    repeat (3) tick();
    check("rst_ready",  32'(ready),  32'd1);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_done",   32'(done),   32'd0);
    check("rst_quot",   32'(quot),   32'd0);
    check("rst_sticky", 32'(sticky), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      run_op(!vecs[i].sq || vecs[i].both, vecs[i].sq || vecs[i].both, vecs[i].a, vecs[i].b, q, s, lat);
      check($sformatf("vec%0d_quot", i),   32'(q),   32'(vecs[i].q));
      check($sformatf("vec%0d_sticky", i), 32'(s),   32'(vecs[i].s));
      check($sformatf("vec%0d_lat", i),    32'(lat), 32'(vecs[i].lat));
      tick();
    end

    for (int i = 0; i < 40; i++) begin
      is_sq = 1'($urandom_range(0, 1));
      ra = is_sq ? 8'($urandom_range(64, 255)) : 8'($urandom_range(128, 255));
      rb = 8'($urandom_range(128, 255));
      model(is_sq, ra, rb, exp_q, exp_s);
      run_op(!is_sq, is_sq, ra, rb, q, s, lat);
      check($sformatf("rnd%0d_quot", i),   32'(q),   32'(exp_q));
      check($sformatf("rnd%0d_sticky", i), 32'(s),   32'(exp_s));
      check($sformatf("rnd%0d_lat", i),    32'(lat), is_sq ? 32'd10 : 32'd11);
      if (i % 3 == 0) tick();
    end

    // Kill four cycles into a division: no Done, previous result retained.
    run_op(1'b1, 1'b0, 8'h80, 8'hC0, q, s, lat);
    check("pre_kill_quot", 32'(q), 32'h0AA);
    tick();
    div_start = 1'b1; a = 8'hFF; b = 8'h80;
    tick();
    div_start = 1'b0;
    repeat (3) tick();
    check("kill_busy_before", 32'(busy), 32'd1);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check("kill_ready", 32'(ready), 32'd1);
    check("kill_busy",  32'(busy),  32'd0);
    check("kill_quot",  32'(quot),  32'h0AA);
    seen = 1'b0;
    repeat (15) begin
      if (done) seen = 1'b1;
      tick();
    end
    check("kill_no_done", 32'(seen), 32'd0);

    // Starts while busy are ignored.
    div_start = 1'b1; a = 8'h80; b = 8'hC0;
    tick();
    div_start = 1'b0;
    tick();
    div_start = 1'b1; sqrt_start = 1'b1; a = 8'hFF; b = 8'h80;
    tick();
    div_start = 1'b0; sqrt_start = 1'b0; a = '0; b = '0;
    lat = 3;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    check("busy_ign_lat",  32'(lat),  32'd11);
    check("busy_ign_quot", 32'(quot), 32'h0AA);
    tick();
    check("busy_ign_idle", 32'(busy), 32'd0);

    // Start accepted in the Done cycle.
    run_op(1'b1, 1'b0, 8'h80, 8'h80, q, s, lat);
    check("b2b_first_quot", 32'(q), 32'h100);
    check("b2b_done_now",   32'(done), 32'd1);
    run_op(1'b0, 1'b1, 8'h80, 8'h00, q, s, lat);
    check("b2b_second_quot",   32'(q),   32'h0B5);
    check("b2b_second_sticky", 32'(s),   32'd1);
    check("b2b_second_lat",    32'(lat), 32'd10);
    tick();

    // Kill in IDLE blocks a coincident start.
    kill = 1'b1; div_start = 1'b1; a = 8'h80; b = 8'h80;
    tick();
    kill = 1'b0; div_start = 1'b0;
    check("kill_idle_busy", 32'(busy), 32'd0);

    // Reset mid-sqrt.
    sqrt_start = 1'b1; a = 8'h90;
    tick();
    sqrt_start = 1'b0;
    repeat (3) tick();
    check("rst_mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    check("rst_mid_ready",  32'(ready),  32'd1);
    check("rst_mid_busy",   32'(busy),   32'd0);
    check("rst_mid_done",   32'(done),   32'd0);
    check("rst_mid_quot",   32'(quot),   32'd0);
    check("rst_mid_sticky", 32'(sticky), 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      if (done) seen = 1'b1;
      tick();
    end
    check("rst_mid_no_done", 32'(seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_sqrt_nr_sequencer.md
Name: div_sqrt_nr_sequencer

Overview:
Sequential control and datapath that drives the non-restoring mantissa recurrence for division and square root, one quotient/root bit per cycle. Accepts normalized mantissas plus a start handshake, then runs the recurrence. Performs a final remainder correction, then presents quotient/root and sticky bit with a one-cycle done pulse. Sits between the div_sqrt operand preprocessing (exponent/special-case handling) and the rounding/normalization stage.

Parameters:
WIDTH, 25, mantissa width including hidden bit
DIV_ITERS, WIDTH+1, division iterations (derived, localparam)
SQRT_ITERS, WIDTH, square-root iterations (derived, localparam)

Ports:
Clk_CI  in  1  clock
Rst_RI  in  1  reset: synchronous, active-high
Div_start_SI  in  1  start division (sampled only when Ready_SO=1)
Sqrt_start_SI  in  1  start square root (sampled only when Ready_SO=1)
Kill_SI  in  1  abort current operation
Mant_a_DI  in  WIDTH  dividend [1,2), hidden bit at MSB; for sqrt: radicand [1,4), 2 integer bits
Mant_b_DI  in  WIDTH  divisor [1,2), hidden bit at MSB; ignored for sqrt
Ready_SO  out  1  able to accept start
Busy_SO  out  1  operation in progress
Done_SO  out  1  one-cycle result-valid pulse
Quotient_DO  out  WIDTH+1  div: value Q/2^WIDTH; sqrt: bits [WIDTH-1:0]=root (value /2^(WIDTH-1)), MSB=0
Sticky_SO  out  1  corrected remainder nonzero

Behaviour:
- Reset: state IDLE; Ready_SO=1; Busy_SO=0; Done_SO=0; Quotient_DO=0; Sticky_SO=0; remainder, divisor and counter regs=0.
- States: IDLE -> DIV_ITER | SQRT_ITER -> CORR -> IDLE.
- IDLE, Div_start_SI=1: latch R=A (signed, WIDTH+3 bits), B, counter=DIV_ITERS -> DIV_ITER. Div_start_SI has priority if both starts high.
- IDLE, Sqrt_start_SI only: latch radicand (zero-extended to 2*WIDTH bits, consumed 2 bits/iter), R=0, root=0, counter=SQRT_ITERS -> SQRT_ITER.
- Starts outside IDLE are ignored.
- DIV_ITER per cycle: if R>=0 then R=2R-B else R=2R+B; q bit = (new R>=0), shifted into quotient LSB. First step uses R=A unshifted-compare form, so the quotient MSB is the integer bit.
- SQRT_ITER per cycle: R'=4R+next2 bits; if R>=0 then R=R'-(4Q+1) else R=R'+(4Q+3); root bit = (new R>=0).
- Counter decrements each iteration; at 1 -> CORR.
- CORR: corrected R = R<0 ? R+divisor_term : R, where divisor_term=B (div) or 2Q+1 (sqrt). Sticky = corrected R != 0. Quotient_DO and Sticky_SO registered -> IDLE with Done_SO=1 for that one cycle.
- Latency: Done_SO high exactly N+2 cycles after the accepting cycle (N = DIV_ITERS or SQRT_ITERS).
- Ready_SO=1 in IDLE, including the Done cycle, so back-to-back starts are allowed and a start in the Done cycle is accepted.
- Quotient_DO/Sticky_SO hold until the next Done. They are not cleared on start.
- Busy_SO = state != IDLE.
- Kill_SI in any non-IDLE state: -> IDLE next cycle, no Done, outputs unchanged. Kill_SI in IDLE: ignored, and a coincident start is not accepted.
- Reset mid-operation: immediate return to reset values, no Done.

Optional Feature:
DIV_SQRT_EARLY_TERM_EN
- Defined: if the new R==0 during an iteration, the remaining quotient bits are forced to 0 (left-shift by the remaining count) and the FSM goes to CORR next cycle. Latency becomes variable, minimum 3.
- Undefined: fixed latency N+2 always.

Decomposition:
- Package div_sqrt_seq_pkg: state enum typedef (IDLE, DIV_ITER, SQRT_ITER, CORR), remainder-width constant WIDTH+3, iteration-count function of WIDTH.
- One combinational sub-module div_sqrt_nr_step: signed add/sub of the shifted remainder with the selected operand, returning the new remainder and the q bit. Instantiated once.

Test Plan (WIDTH=8):
- Div A=0x80, B=0x80 -> Quotient_DO=0x100, Sticky_SO=0, Done_SO exactly 11 cycles after accept.
- Div A=0x80, B=0xC0 -> Quotient_DO=0x0AA, Sticky_SO=1.
- Sqrt A=0x90 (2.25) -> Quotient_DO=0x0C0, Sticky_SO=0, Done after 10 cycles. Sqrt A=0x80 (2.0) -> 0x0B5, Sticky_SO=1.
- Kill_SI asserted 4 cycles into a division -> no Done_SO, Ready_SO=1 next cycle, previous Quotient_DO retained. Start asserted while Busy_SO=1 -> ignored.
- Both starts high in IDLE -> division performed. Start in the Done cycle -> accepted, second result correct.
- Rst_RI mid-sqrt -> all outputs at reset values next cycle. With DIV_SQRT_EARLY_TERM_EN, div 0x80/0x80 -> Done after 3 cycles, Quotient_DO=0x100.
